// File: rtl/fptd_pkg.sv
// Shared definitions for the fptd max-log-MAP decoder: trellis shape, metric
// classes and the successor table used by both the alpha and beta recursions.
package fptd_pkg;

  localparam int NUM_STATES = 8;
  localparam int BM_W       = 5;
  localparam int METRIC_W   = 6;
  localparam int LIFO_DEPTH = 32;

  typedef enum logic [1:0] {G0, G2, G13, G3} metric_class_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} bbu_state_e;

  // States 1..7 only; state 0 is the normalization reference and always 0.
  typedef logic [NUM_STATES-1:1][METRIC_W-1:0] beta_vec_t;

  typedef struct packed {
    logic [2:0]    to_state;
    metric_class_e cls;
  } succ_t;

  localparam succ_t SUCC [NUM_STATES][2] = '{
    '{'{3'd0, G0 }, '{3'd4, G3 }},
    '{'{3'd0, G3 }, '{3'd4, G0 }},
    '{'{3'd1, G13}, '{3'd5, G2 }},
    '{'{3'd1, G2 }, '{3'd5, G13}},
    '{'{3'd2, G2 }, '{3'd6, G13}},
    '{'{3'd2, G13}, '{3'd6, G2 }},
    '{'{3'd3, G3 }, '{3'd7, G0 }},
    '{'{3'd3, G0 }, '{3'd7, G3 }}
  };

endpackage

// File: rtl/beta_acs_step.sv
// One backward add-compare-select step: successor sums, max, normalization
// against state 0 and saturation back to the state-metric width.
module beta_acs_step
  import fptd_pkg::*;
#(
  parameter int N = BM_W,
  parameter int M = METRIC_W
) (
  input  logic [NUM_STATES-1:1][M-1:0] i_beta,
  input  logic [N-1:0]                 i_g2,
  input  logic [M:0]                   i_g13,
  input  logic [M:0]                   i_g3,
  output logic [NUM_STATES-1:1][M-1:0] o_beta
);

  localparam int SAT_MAX = 2**(M-1) - 1;
  localparam int SAT_MIN = -(2**(M-1));

  function automatic logic [M-1:0] bit_clip(input logic signed [M+2:0] v);
    if (int'(v) > SAT_MAX) return M'(SAT_MAX);
    if (int'(v) < SAT_MIN) return M'(SAT_MIN);
    return v[M-1:0];
  endfunction

  logic signed [M+1:0] w_b    [NUM_STATES];
  logic signed [M+1:0] w_g    [4];
  logic signed [M+1:0] w_c0   [NUM_STATES];
  logic signed [M+1:0] w_c1   [NUM_STATES];
  logic signed [M+1:0] w_bp   [NUM_STATES];
  logic signed [M+2:0] w_norm [1:NUM_STATES-1];

  always_comb begin
    w_g[G0]  = '0;
    w_g[G2]  = (M+2)'(signed'(i_g2));
    w_g[G13] = (M+2)'(signed'(i_g13));
    w_g[G3]  = (M+2)'(signed'(i_g3));
    w_b[0]   = '0;
    for (int s = 1; s < NUM_STATES; s++) w_b[s] = (M+2)'(signed'(i_beta[s]));
    for (int s = 0; s < NUM_STATES; s++) begin
      w_c0[s] = w_b[SUCC[s][0].to_state] + w_g[SUCC[s][0].cls];
      w_c1[s] = w_b[SUCC[s][1].to_state] + w_g[SUCC[s][1].cls];
      w_bp[s] = (w_c0[s] > w_c1[s]) ? w_c0[s] : w_c1[s];
    end
    // One extra bit so the difference of two extremes cannot wrap.
    o_beta = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      w_norm[s] = (M+3)'(w_bp[s]) - (M+3)'(w_bp[0]);
      o_beta[s] = bit_clip(w_norm[s]);
    end
  end

endmodule

// File: rtl/beta_backward_unit.sv
// Beta recursion engine: collects branch metrics into a LIFO during the
// forward pass, then replays them newest-first producing one beta vector/cycle.
module beta_backward_unit
  import fptd_pkg::*;
#(
  parameter int N  = BM_W,
  parameter int M  = METRIC_W,
  parameter int W  = LIFO_DEPTH,
  parameter int AW = $clog2(W + 1)
) (
  input  logic                         Clock,
  input  logic                         nReset,
  input  logic                         nClear,
  input  logic                         Push,
  input  logic signed [N-1:0]          ba2,
  input  logic signed [M:0]            ba1ba3,
  input  logic signed [M:0]            ba1ba2ba3,
  input  logic                         Terminated,
  input  logic                         Start,
  output logic [NUM_STATES-1:1][M-1:0] beta_out,
  output logic                         Valid,
  output logic [AW-1:0]                Step,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Overflow
);

  localparam int IW = $clog2(W);
  localparam logic [M-1:0] BETA_FLOOR = {1'b1, {(M-1){1'b0}}};

  typedef struct packed {
    logic [N-1:0] g2;
    logic [M:0]   g13;
    logic [M:0]   g3;
  } triple_t;

  bbu_state_e                   r_state, w_next_state;
  triple_t                      r_stack [W];
  logic [AW-1:0]                r_count, r_pend_step;
  logic [NUM_STATES-1:1][M-1:0] r_beta, w_beta_next;
  logic                         r_pend_v, r_done_d;
  logic [IW-1:0]                w_wr_idx, w_rd_idx;
  triple_t                      w_rd;
  logic                         w_push_ok, w_push_drop, w_start_ok, w_run, w_last;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)      r_state <= S_IDLE;
    else if (!nClear) r_state <= S_IDLE;
    else              r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_RUN;
      S_RUN:   if (w_last)     w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // A push in the same cycle as Start is counted before the pass begins.
  always_comb begin
    w_run       = (r_state == S_RUN);
    w_push_ok   = (r_state == S_IDLE) && Push && (r_count != AW'(W));
    w_push_drop = Push && !w_push_ok;
    w_start_ok  = (r_state == S_IDLE) && Start && ((r_count != '0) || w_push_ok);
    w_last      = w_run && (r_count == AW'(1));
  end

  assign Busy     = (r_state != S_IDLE);
  assign w_wr_idx = IW'(r_count);
  assign w_rd_idx = IW'(r_count - AW'(1));
  assign w_rd     = r_stack[w_rd_idx];

  // NOTE: the LIFO storage has no reset; only entries below the live count are ever read.
  always_ff @(posedge Clock) begin
    if (w_push_ok) r_stack[w_wr_idx] <= '{g2: ba2, g13: ba1ba3, g3: ba1ba2ba3};
  end

  beta_acs_step #(.N(N), .M(M)) u_acs (
    .i_beta (r_beta),
    .i_g2   (w_rd.g2),
    .i_g13  (w_rd.g13),
    .i_g3   (w_rd.g3),
    .o_beta (w_beta_next)
  );

  // NOTE: non-blocking assignments make every register here sample pre-edge values.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_count     <= '0;
      r_beta      <= '0;
      r_pend_v    <= 1'b0;
      r_pend_step <= '0;
      r_done_d    <= 1'b0;
      beta_out    <= '0;
      Valid       <= 1'b0;
      Step        <= '0;
      Done        <= 1'b0;
      Overflow    <= 1'b0;
    end else if (!nClear) begin
      r_count     <= '0;
      r_beta      <= '0;
      r_pend_v    <= 1'b0;
      r_pend_step <= '0;
      r_done_d    <= 1'b0;
      beta_out    <= '0;
      Valid       <= 1'b0;
      Step        <= '0;
      Done        <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      if (w_push_ok)  r_count <= r_count + AW'(1);
      else if (w_run) r_count <= r_count - AW'(1);
      if (w_start_ok) r_beta <= Terminated ? {(NUM_STATES-1){BETA_FLOOR}} : '0;
      else if (w_run) r_beta <= w_beta_next;
      // Output stage trails the recursion register by one cycle.
      r_pend_v    <= w_run;
      r_pend_step <= r_count - AW'(1);
      Valid       <= r_pend_v;
      if (r_pend_v) begin
        beta_out <= r_beta;
        Step     <= r_pend_step;
      end
      r_done_d <= (r_state == S_DONE);
      Done     <= r_done_d;
      Overflow <= Overflow | w_push_drop;
    end
  end

endmodule

// File: tb/tb_beta_backward_unit.sv
// Directed bench for beta_backward_unit: an independent recursion model fills
// a scoreboard at Start and a monitor compares every Valid vector against it.
module tb_beta_backward_unit;
  import fptd_pkg::*;

  localparam int N  = BM_W;
  localparam int M  = METRIC_W;
  localparam int W  = LIFO_DEPTH;
  localparam int AW = $clog2(W + 1);
  localparam int SMAX = 2**(M-1) - 1;
  localparam int SMIN = -(2**(M-1));

  typedef struct { int g2; int g13; int g3; } trip_t;
  typedef struct { beta_vec_t beta; int step; } exp_t;

  logic                         Clock = 1'b0;
  logic                         nReset, nClear, Push, Terminated, Start;
  logic [N-1:0]                 ba2;
  logic [M:0]                   ba1ba3, ba1ba2ba3;
  logic [NUM_STATES-1:1][M-1:0] beta_out;
  logic                         Valid;
  logic [AW-1:0]                Step;
  logic                         Busy, Done, Overflow;

  int    checks = 0;
  int    failures = 0;
  bit    m_ovf = 1'b0;
  trip_t m_stack[$];
  exp_t  sb[$];
  exp_t  mon_e;

  beta_backward_unit #(.N(N), .M(M), .W(W)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .nClear     (nClear),
    .Push       (Push),
    .ba2        (ba2),
    .ba1ba3     (ba1ba3),
    .ba1ba2ba3  (ba1ba2ba3),
    .Terminated (Terminated),
    .Start      (Start),
    .beta_out   (beta_out),
    .Valid      (Valid),
    .Step       (Step),
    .Busy       (Busy),
    .Done       (Done),
    .Overflow   (Overflow)
  );

  always #5 Clock = ~Clock;

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic beta_vec_t ref_step(input beta_vec_t bi, input trip_t t);
    int b[8];
    int bp[8];
    int n;
    beta_vec_t r;
    b[0] = 0;
    for (int s = 1; s < 8; s++) b[s] = int'(signed'(bi[s]));
    bp[0] = mx(b[0], b[4] + t.g3);
    bp[1] = mx(b[0] + t.g3, b[4]);
    bp[2] = mx(b[1] + t.g13, b[5] + t.g2);
    bp[3] = mx(b[1] + t.g2, b[5] + t.g13);
    bp[4] = mx(b[2] + t.g2, b[6] + t.g13);
    bp[5] = mx(b[2] + t.g13, b[6] + t.g2);
    bp[6] = mx(b[3] + t.g3, b[7]);
    bp[7] = mx(b[3], b[7] + t.g3);
    r = '0;
    for (int s = 1; s < 8; s++) begin
      n = bp[s] - bp[0];
      if (n > SMAX) n = SMAX;
      if (n < SMIN) n = SMIN;
      r[s] = M'(n);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input int g2, input int g13, input int g3);
    trip_t t;
    ba2 = N'(g2); ba1ba3 = (M+1)'(g13); ba1ba2ba3 = (M+1)'(g3);
    Push = 1'b1;
    tick();
    Push = 1'b0;
    t.g2 = g2; t.g13 = g13; t.g3 = g3;
    if (m_stack.size() < W) m_stack.push_back(t);
    else m_ovf = 1'b1;
  endtask

  task automatic push_rand();
    push(int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 127)) - 64,
         int'($urandom_range(0, 127)) - 64);
  endtask

  task automatic start(input bit term);
    beta_vec_t b;
    exp_t e;
    Terminated = term; Start = 1'b1;
    tick();
    Start = 1'b0;
    if (m_stack.size() == 0) return;
    b = '0;
    if (term) for (int s = 1; s < 8; s++) b[s] = M'(SMIN);
    for (int i = m_stack.size() - 1; i >= 0; i--) begin
      b = ref_step(b, m_stack[i]);
      e.beta = b; e.step = i;
      sb.push_back(e);
    end
    m_stack.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clock);
      seen = Done;
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_beta"},  64'(beta_out), 64'd0);
    check({tag, "_valid"}, 64'(Valid),    64'd0);
    check({tag, "_step"},  64'(Step),     64'd0);
    check({tag, "_busy"},  64'(Busy),     64'd0);
    check({tag, "_done"},  64'(Done),     64'd0);
    check({tag, "_ovf"},   64'(Overflow), 64'd0);
  endtask

  always @(negedge Clock) begin
    if (Valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(Valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("beta_out", 64'(beta_out), 64'(mon_e.beta));
        check("step", 64'(Step), 64'(mon_e.step));
      end
    end
  end

  initial begin
    nReset = 1'b0; nClear = 1'b1; Push = 1'b0; Start = 1'b0; Terminated = 1'b0;
    ba2 = '0; ba1ba3 = '0; ba1ba2ba3 = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_cleared("reset");
    nReset = 1'b1;
    tick();

    // Single-step passes with hand-checkable vectors.
    push(3, 0, 0);   start(1'b0); wait_done("t1", 10);
    push(0, 0, 0);   start(1'b1); wait_done("t2", 10);
    push(15, 63, 0); start(1'b0); wait_done("t3", 10);

    // Three steps: newest-first replay, Start-to-Valid latency, Done placement.
    push(5, -7, 2); push(-3, 20, -9); push(11, -40, 33);
    start(1'b0);
    @(negedge Clock); check("lat_e0_valid", 64'(Valid), 64'd0);
                      check("lat_e0_busy",  64'(Busy),  64'd1);
    @(negedge Clock); check("lat_e1_valid", 64'(Valid), 64'd0);
    @(negedge Clock); check("lat_e2_valid", 64'(Valid), 64'd1);
    @(negedge Clock); check("lat_e3_valid", 64'(Valid), 64'd1);
                      check("lat_e3_done",  64'(Done),  64'd0);
    @(negedge Clock); check("lat_e4_valid", 64'(Valid), 64'd1);
                      check("lat_e4_done",  64'(Done),  64'd0);
    @(negedge Clock); check("lat_e5_valid", 64'(Valid), 64'd0);
                      check("lat_e5_done",  64'(Done),  64'd1);
    @(negedge Clock); check("lat_e6_done",  64'(Done),  64'd0);
                      check("lat_e6_busy",  64'(Busy),  64'd0);
    check("lat_drained", 64'(sb.size()), 64'd0);

    // Push while busy is dropped and flags Overflow; the pass is unaffected.
    push_rand(); push_rand(); push_rand();
    start(1'b0);
    ba2 = N'(7); Push = 1'b1;
    tick();
    Push = 1'b0; m_ovf = 1'b1;
    check("busy_push_ovf", 64'(Overflow), 64'(m_ovf));
    wait_done("t5", 20);
    nClear = 1'b0;
    tick();
    nClear = 1'b1; m_ovf = 1'b0;
    check("clear_ovf", 64'(Overflow), 64'(m_ovf));

    // Fill to depth, overflow by one, replay the full window, then empty Start.
    for (int i = 0; i < W; i++) push_rand();
    check("full_no_ovf", 64'(Overflow), 64'(m_ovf));
    push_rand();
    check("full_ovf", 64'(Overflow), 64'(m_ovf));
    start(1'b1);
    wait_done("t6", W + 10);
    start(1'b0);
    @(negedge Clock); check("empty_start_busy", 64'(Busy), 64'd0);
    repeat (3) @(negedge Clock);
    check("empty_start_valid", 64'(Valid), 64'd0);

    // Asynchronous reset in the middle of a pass.
    for (int i = 0; i < 5; i++) push_rand();
    start(1'b0);
    repeat (4) @(negedge Clock);
    @(posedge Clock);
    #2;
    nReset = 1'b0;
    #1;
    check_cleared("abort_rst");
    sb.delete(); m_stack.delete(); m_ovf = 1'b0;
    repeat (2) tick();
    nReset = 1'b1;
    repeat (6) @(negedge Clock);
    check("abort_rst_quiet", 64'(Valid), 64'd0);

    // Synchronous clear in the middle of a pass.
    for (int i = 0; i < 5; i++) push_rand();
    start(1'b0);
    repeat (3) tick();
    nClear = 1'b0;
    tick();
    nClear = 1'b1;
    check_cleared("abort_clr");
    sb.delete(); m_stack.delete();
    repeat (6) @(negedge Clock);
    check("abort_clr_quiet", 64'(Valid), 64'd0);
    check("abort_clr_idle", 64'(Busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beta_backward_unit.md
Name: beta_backward_unit

Overview:
- Backward (beta) recursion engine for the 8-state max-log-MAP decoder. It is the counterpart of the forward alpha recursion.
- During the forward pass it collects per-step branch metrics into a LIFO. On Start it replays them newest-first and produces one state-0-normalized, saturated beta vector per cycle.
- It sits beside the alpha unit and feeds the LLR/extrinsic stage.

Parameters:
- N, 5, width of signed branch metric ba2.
- M, 6, width of signed state metrics; ba1ba3 and ba1ba2ba3 are M+1 bits.
- W, 32, LIFO depth (maximum window length in trellis steps); AW = $clog2(W+1).

Ports:
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous active-low reset.
- nClear  in  1  synchronous active-low clear; same effect as reset, at the next edge.
- Push  in  1  write one metric triple into the LIFO.
- ba2  in  N  signed metric G2.
- ba1ba3  in  M+1  signed metric G13.
- ba1ba2ba3  in  M+1  signed metric G3.
- Terminated  in  1  sampled on Start: 1 = trellis terminated in state 0; 0 = equiprobable start.
- Start  in  1  begin backward pass.
- beta_out  out  [7:1][M-1:0]  signed normalized betas; beta[0] is implicitly 0.
- Valid  out  1  beta_out holds a new vector this cycle.
- Step  out  AW  trellis index of beta_out (0 = oldest pushed step).
- Busy  out  1  FSM is not IDLE.
- Done  out  1  one-cycle pulse after the last vector.
- Overflow  out  1  sticky: a Push was dropped.

Behaviour:
- Reset/clear: FSM=IDLE, count=0, beta_reg=0, beta_out=0, Valid=0, Step=0, Done=0, Overflow=0. LIFO contents are don't-care. Reset mid-RUN aborts with no further Valid.
- FSM states IDLE, RUN, DONE.
  - IDLE: Push with count<W writes stack[count] and increments count.
  - IDLE, Push with count==W: the push is dropped and Overflow is set.
  - IDLE, Start with count>0: go to RUN. beta_reg <= init, where init is all 0 if Terminated=0, else -2^(M-1) for states 1..7. Start with count==0 is ignored.
  - IDLE, Start and Push in the same cycle: the push is accepted and counted before the pass begins.
  - RUN: each cycle, beta_reg <= step(beta_reg, stack[count-1]), count decrements, and Valid=1 is registered with beta_out=new beta_reg and Step=count-1. When count reaches 0, go to DONE.
  - DONE: Done=1 for one cycle, then IDLE.
  - Push or Start while Busy: ignored; Push sets Overflow.
- Latency: Start at edge t gives the first Valid after edge t+2. K pushed steps give exactly K consecutive Valid cycles, with Step running K-1 down to 0. Done is asserted on the cycle after the last Valid.
- step() recursion, with b0=0 and G0=0:
  - b'0=max(b0, b4+G3); b'1=max(b0+G3, b4)
  - b'2=max(b1+G13, b5+G2); b'3=max(b1+G2, b5+G13)
  - b'4=max(b2+G2, b6+G13); b'5=max(b2+G13, b6+G2)
  - b'6=max(b3+G3, b7); b'7=max(b3, b7+G3)
- Width rules:
  - Sums are signed M+2 bits.
  - Normalization: out_s = b'_s - b'_0, computed in M+3 bits.
  - Saturate to M bits signed, range [-2^(M-1), 2^(M-1)-1], then register.
- Valid, Done and Step are fully registered; no combinational path from inputs to outputs.

Decomposition:
- Package fptd_pkg holds:
  - NUM_STATES=8.
  - A typedef for metric vectors.
  - The successor table as constants (from-state -> {to-state, metric class}) shared with the alpha unit.
  - The metric-class enum {G0, G2, G13, G3}.
- Sub-module beta_acs_step: the combinational recursion, normalization and BitClip saturation (reuses existing BitClip). The top level holds the LIFO, counters and FSM.

Test Plan:
- Push {ba2=3, ba1ba3=0, ba1ba2ba3=0}, Start with Terminated=0 -> one Valid, Step=0, beta_out[1..7]={0,3,3,3,3,0,0}, then Done.
- Push zeros, Start with Terminated=1 -> beta_out={0,-32,-32,-32,-32,-32,-32}.
- Push {15, 63, 0}, Terminated=0 -> beta_out[2]=31 (saturated), beta_out[5]=31, beta_out[1]=0.
- Push 3 distinct triples A, B, C -> 3 Valids processed in C, B, A order with Step 2, 1, 0. Start at t gives first Valid at t+2; Done follows the last Valid.
- Push W+1 times -> count=W, Overflow=1. Start gives W Valids. Start with an empty LIFO gives no activity.
- Assert nReset mid-RUN -> all outputs 0 immediately and no further Valid. nClear mid-RUN gives the same result at the next edge.
